// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch and load/store requesters,
// the memory-port arbiter, and the single memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_rdata;
  logic              if_err;

  logic              ls_req;
  logic              ls_we;
  logic [3:0]        ls_be;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_done;
  logic              ls_err;
  logic [31:0]       ls_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_ack, mem_rdata,
    output if_done, if_rdata, if_err, ls_done, ls_rdata, ls_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_ack, mem_rdata,
    input  if_done, if_rdata, if_err, ls_done, ls_rdata, ls_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto one memory port with
// alternating tie-break and an ISSUE-phase timeout that aborts with err=1.
module mem_port_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic       OWN_IF  = 1'b0;
  localparam logic       OWN_LS  = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              if_done_q, if_done_d, ls_done_q, ls_done_d;
  logic              if_err_q, if_err_d, ls_err_q, ls_err_d;
  logic [31:0]       if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;

  logic any_req, grant_ls, timeout, finish;
  logic [31:0] cap_rdata;

  assign any_req   = bus.if_req | bus.ls_req;
  // On a tie the requester that did not finish last wins.
  assign grant_ls  = bus.ls_req & (~bus.if_req | (last_q == OWN_IF));
  assign timeout   = (cnt_q == TO_LAST);
  assign finish    = bus.mem_ack | timeout;
  assign cap_rdata = bus.mem_ack ? bus.mem_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (finish)  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    if_err_d    = if_err_q;
    ls_err_d    = ls_err_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    case (state_q)
      IDLE: if (any_req) begin
        owner_d   = grant_ls ? OWN_LS : OWN_IF;
        cnt_d     = 8'd0;
        mem_req_d = 1'b1;
        if (grant_ls) begin
          mem_we_d    = bus.ls_we;
          mem_be_d    = bus.ls_be;
          mem_addr_d  = bus.ls_addr;
          mem_wdata_d = bus.ls_wdata;
        end else begin
          mem_we_d    = 1'b0;
          mem_be_d    = 4'hF;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = 32'h0;
        end
      end
      ISSUE: if (finish) begin
        // An ack in the timeout cycle still counts as a normal completion.
        mem_req_d = 1'b0;
        last_d    = owner_q;
        if (owner_q == OWN_LS) begin
          ls_done_d  = 1'b1;
          ls_err_d   = ~bus.mem_ack;
          ls_rdata_d = cap_rdata;
        end else begin
          if_done_d  = 1'b1;
          if_err_d   = ~bus.mem_ack;
          if_rdata_d = cap_rdata;
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_IF;
      last_q      <= OWN_LS;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'h0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      ls_err_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      ls_rdata_q  <= 32'h0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      if_err_q    <= if_err_d;
      ls_err_q    <= ls_err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_err    = if_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_done   = ls_done_q;
  assign bus.ls_err    = ls_err_q;
  assign bus.ls_rdata  = ls_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: completions are predicted into a
// scoreboard queue when ack/timeout is driven and checked on each done pulse.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 24;
  localparam int TO     = 4;

  typedef struct {
    logic        ls;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   checks = 0;
  int   failures = 0;
  int   n_if_done = 0;
  int   n_ls_done = 0;
  exp_t sb[$];

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every done pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (bus.if_done === 1'b1 || bus.ls_done === 1'b1) begin
      exp_t e;
      if (bus.if_done === 1'b1) n_if_done++;
      if (bus.ls_done === 1'b1) n_ls_done++;
      chk("single_done", {63'h0, bus.if_done & bus.ls_done}, 64'h0);
      if (sb.size() == 0) begin
        chk("unexpected_done", {62'h0, bus.if_done, bus.ls_done}, 64'h0);
      end else begin
        e = sb.pop_front();
        chk("done_owner", {63'h0, bus.ls_done}, {63'h0, e.ls});
        chk("rdata", {32'h0, e.ls ? bus.ls_rdata : bus.if_rdata}, {32'h0, e.rd});
        chk("err", {63'h0, e.ls ? bus.ls_err : bus.if_err}, {63'h0, e.err});
      end
    end
  end

  // Called just after the granting edge; walks the ISSUE phase checking a
  // stable payload, optionally acking in cycle ack_at (-1 = never).
  task automatic issue(input logic exp_ls, input int ack_at, input logic [31:0] rd,
                       output int ncyc);
    logic [ADDR_W-1:0] ea;
    logic              ewe;
    logic [3:0]        ebe;
    logic [31:0]       ewd;
    exp_t              e;
    ea   = exp_ls ? bus.ls_addr  : bus.if_addr;
    ewe  = exp_ls ? bus.ls_we    : 1'b0;
    ebe  = exp_ls ? bus.ls_be    : 4'hF;
    ewd  = exp_ls ? bus.ls_wdata : 32'h0;
    ncyc = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.mem_req !== 1'b1) break;
      ncyc++;
      chk("mem_addr",  {40'h0, bus.mem_addr}, {40'h0, ea});
      chk("mem_we",    {63'h0, bus.mem_we},   {63'h0, ewe});
      chk("mem_be",    {60'h0, bus.mem_be},   {60'h0, ebe});
      chk("mem_wdata", {32'h0, bus.mem_wdata}, {32'h0, ewd});
      chk("busy_issue", {63'h0, busy}, 64'h1);
      e.ls = exp_ls;
      if (k == ack_at) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rd;
        e.rd = rd; e.err = 1'b0;
        sb.push_back(e);
      end else if (k == TO - 1) begin
        e.rd = 32'h0; e.err = 1'b1;
        sb.push_back(e);
      end
      tick();
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 32'hBAD0BAD0;
    end
    chk("owner_done", {63'h0, exp_ls ? bus.ls_done : bus.if_done}, 64'h1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = '0;
    bus.ls_req = 0; bus.ls_we = 0; bus.ls_be = 0; bus.ls_addr = '0; bus.ls_wdata = 0;
    bus.mem_ack = 0; bus.mem_rdata = 32'hBAD0BAD0;
    tick(); tick();
    chk("rst_mem_req", {63'h0, bus.mem_req}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_payload", {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}, 64'h0);
    chk("rst_done_err", {60'h0, bus.if_done, bus.ls_done, bus.if_err, bus.ls_err}, 64'h0);
    chk("rst_rdata", {bus.if_rdata, bus.ls_rdata}, 64'h0);
    rst = 1'b0;

    // Tie: both held, each re-raised after its done -> IF, LS, IF, LS
    bus.if_req = 1; bus.if_addr = 24'h000400;
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_be = 4'hF; bus.ls_addr = 24'h000800;
    for (int i = 0; i < 4; i++) begin
      tick();
      issue(i[0], i % 2, 32'h1000_0000 + i, n);
      chk("tie_reqcyc", n, (i % 2) + 1);
      if (i[0]) bus.ls_req = 0; else bus.if_req = 0;
      tick();
      chk("tie_idle_busy", {63'h0, busy}, 64'h0);
      if (i < 3) begin
        if (i[0]) bus.ls_req = 1; else bus.if_req = 1;
      end else bus.if_req = 0;
    end

    // Single fetch with immediate ack
    bus.if_req = 1; bus.if_addr = 24'h000100;
    tick();
    issue(1'b0, 0, 32'h00000013, n);
    chk("fetch_reqcyc", n, 1);
    bus.if_req = 0;
    tick();

    // Store, ack after 3 wait cycles (also lands on the timeout cycle)
    bus.ls_req = 1; bus.ls_we = 1; bus.ls_be = 4'b0011;
    bus.ls_addr = 24'h000200; bus.ls_wdata = 32'hDEADBEEF;
    tick();
    issue(1'b1, 3, 32'h5A5A_0001, n);
    chk("store_reqcyc", n, 4);
    bus.ls_req = 0;
    tick();

    // Timeout with no ack, then a late ack in IDLE
    bus.ls_req = 1; bus.ls_we = 0; bus.ls_be = 4'hF; bus.ls_addr = 24'h000300;
    tick();
    issue(1'b1, -1, 32'h0, n);
    chk("timeout_reqcyc", n, TO);
    bus.ls_req = 0;
    tick();
    bus.mem_ack = 1; bus.mem_rdata = 32'h12345678;
    tick();
    bus.mem_ack = 0;
    chk("late_ack_mem_req", {63'h0, bus.mem_req}, 64'h0);
    chk("late_ack_busy", {63'h0, busy}, 64'h0);
    chk("late_ack_done", {62'h0, bus.if_done, bus.ls_done}, 64'h0);

    // Fetch with ack coincident with the timeout cycle
    bus.if_req = 1; bus.if_addr = 24'h000500;
    tick();
    issue(1'b0, TO - 1, 32'hCAFEF00D, n);
    chk("coinc_reqcyc", n, TO);
    bus.if_req = 0;
    tick();

    // Reset during the second ISSUE cycle of a load/store
    bus.ls_req = 1; bus.ls_addr = 24'h000600;
    tick();
    chk("pre_rst_mem_req", {63'h0, bus.mem_req}, 64'h1);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_mem_req", {63'h0, bus.mem_req}, 64'h0);
    chk("abort_busy", {63'h0, busy}, 64'h0);
    rst = 1'b0;
    bus.if_req = 1; bus.if_addr = 24'h000700;
    tick();
    issue(1'b0, 0, 32'h0000_7777, n);
    chk("post_rst_tie_if", n, 1);
    bus.if_req = 0; bus.ls_req = 0;
    tick(); tick();

    chk("if_done_count", n_if_done, 5);
    chk("ls_done_count", n_ls_done, 4);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24, byte-address width of all address ports.
REQ-002 Parameter TIMEOUT_CYC, default 255, range 1..255; maximum ISSUE cycles allowed before abort.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  instruction-fetch read request; held with if_addr until if_done.
REQ-006 if_addr  in  ADDR_W  fetch address.
REQ-007 if_done  out  1  one-cycle completion pulse to fetch.
REQ-008 if_rdata  out  32  fetch read data; valid while if_done=1.
REQ-009 if_err  out  1  fetch timed out; valid while if_done=1.
REQ-010 ls_req, ls_we, ls_be[3:0], ls_addr[ADDR_W], ls_wdata[32]  in  load/store request, write enable, byte strobes, address, write data; held until ls_done.
REQ-011 ls_done, ls_err  out  1 each; ls_rdata  out  32  same semantics as the fetch outputs.
REQ-012 mem_req  out  1  memory-port transaction request.
REQ-013 mem_we, mem_be[4], mem_addr[ADDR_W], mem_wdata[32]  out  registered transaction payload.
REQ-014 mem_ack  in  1  memory completes the transaction in any cycle where mem_req=1 and mem_ack=1.
REQ-015 mem_rdata  in  32  read data, valid with mem_ack.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, ISSUE, RESP; state is one-hot or encoded, implementer's choice.
REQ-018 IDLE: if any request is sampled high, latch the winner's payload into the mem_* registers, record the owner, clear the timeout counter, go to ISSUE; otherwise stay in IDLE.
REQ-019 Fetch payload: mem_we=0, mem_be=4'hF, mem_wdata=0; load/store payload is copied unchanged.
REQ-020 Arbitration: if exactly one request is high, grant it; if both are high, grant the requester other than last_owner.
REQ-021 last_owner updates only on entry to RESP.
REQ-022 ISSUE: mem_req=1 and the payload is held constant; mem_ack=1 captures mem_rdata and transitions to RESP with err=0.
REQ-023 The timeout counter increments on every ISSUE cycle without ack; when the count reaches TIMEOUT_CYC, drop mem_req, capture rdata=0, and go to RESP with err=1.
REQ-024 If ack and timeout occur in the same cycle, the ack wins (err=0).
REQ-025 RESP lasts exactly one cycle: the owner's done=1 with the registered rdata/err; the other requester's done=0; then go to IDLE.
REQ-026 mem_ack is ignored in IDLE and RESP, including a late ack after a timeout.
REQ-027 A requester may deassert or change its request on the edge ending its done cycle; a request sampled in IDLE is always a new transaction.
REQ-028 Latency with immediate ack: request sampled in IDLE at edge N; mem_req=1 in cycle N+1; done=1 in cycle N+2.
REQ-029 Request lines have no effect during ISSUE and RESP; no request is queued or dropped, because requests are held.
REQ-030 done, rdata and err outputs are registered; mem_* outputs are registered.

Reset
REQ-031 While rst=1 at an edge: state=IDLE, last_owner=LS (so fetch wins the first tie), counter=0, and all outputs 0 (mem_req, mem_we, mem_be, mem_addr, mem_wdata, both done, both err, both rdata, busy).
REQ-032 Reset mid-transaction aborts without a done pulse; mem_req is low from the cycle after the reset edge.

Verification
REQ-033 Single fetch: if_req=1, if_addr=0x000100; mem_ack in the first ISSUE cycle with mem_rdata=0x00000013 -> mem_addr=0x000100, mem_we=0, mem_be=F; if_done=1 two cycles after grant with if_rdata=0x00000013 and if_err=0.
REQ-034 Store: ls_we=1, ls_be=4'b0011, ls_addr=0x000200, ls_wdata=0xDEADBEEF; ack delayed 3 cycles -> mem_req high for 4 cycles with a stable payload; ls_done pulses once.
REQ-035 Simultaneous requests after reset, both held and re-raised -> grant order IF, LS, IF, LS; exactly one done per transaction.
REQ-036 Timeout: TIMEOUT_CYC=4, no ack -> mem_req high for 4 cycles, then ls_done=1, ls_err=1, ls_rdata=0; an ack in the following IDLE cycle has no effect.
REQ-037 Reset asserted in the second ISSUE cycle -> mem_req=0 and busy=0 in the next cycle; no done; next tie is granted to IF.
REQ-038 Ack coincident with the timeout cycle -> err=0 and the captured rdata is delivered.
